nts_tx_mac_feeder: RTL and testbench

NTS_TX_MAC_FEEDER -- requirements
Module: nts_tx_mac_feeder

---
 rtl/nts_tx_mac_feeder.sv | 154 +++++++++++++++
 tb/tb_nts_tx_mac_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_tx_mac_feeder.sv
// Store-and-forward feeder: drains one engine TX packet into a local buffer, then streams it to the MAC.
// Optional build macro NTS_TX_MIN_FRAME_PAD_EN zero-pads short frames to the 60-byte minimum.
//
// state   | meaning
// IDLE    | waiting for an engine packet
// RD_REQ  | issue a FIFO read, or finish draining when the FIFO is empty
// RD_CAPT | capture the word returned by the previous read
// RELEASE | hand the packet back to the engine; drop it if empty or oversized
// TX_REQ  | request the MAC and wait for its ack
// TX_DATA | stream buffered words, one per cycle
module nts_tx_mac_feeder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAC_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_areset_n,
  input  logic                      i_engine_packet_available,
  output logic                      o_engine_packet_read,
  input  logic                      i_engine_fifo_empty,
  output logic                      o_engine_fifo_rd_en,
  input  logic [MAC_DATA_WIDTH-1:0] i_engine_fifo_rd_data,
  input  logic [3:0]                i_engine_bytes_last_word,
  output logic                      o_mac_tx_start,
  input  logic                      i_mac_tx_ack,
  output logic [7:0]                o_mac_tx_data_valid,
  output logic [MAC_DATA_WIDTH-1:0] o_mac_tx_data,
  output logic                      o_busy,
  output logic [31:0]               o_tx_packets,
  output logic [31:0]               o_tx_drops
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_CAPT, RELEASE, TX_REQ, TX_DATA
  } state_t;

  state_t state_q, state_d;

  logic [MAC_DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [CW-1:0]             word_cnt, tx_idx, tx_words;
  logic                      overflow;
  logic [3:0]                bytes_last, n_eff;
  logic [7:0]                last_mask, mask_eff;
  logic                      pad_active, last_word;
  logic [MAC_DATA_WIDTH-1:0] tx_word;

  always_comb begin
    n_eff = bytes_last;
    if (bytes_last == 4'd0 || bytes_last > 4'd8) n_eff = 4'd8;
    last_mask = 8'hFF << (4'd8 - n_eff);
  end

`ifdef NTS_TX_MIN_FRAME_PAD_EN
  logic [CW+2:0] frame_bytes;
  assign frame_bytes = {word_cnt, 3'b000} - (CW+3)'(8) + (CW+3)'(n_eff);
  assign pad_active  = frame_bytes < (CW+3)'(60);
  assign tx_words    = pad_active ? CW'(8) : word_cnt;
  assign mask_eff    = pad_active ? 8'hF0 : last_mask;
`else
  assign pad_active  = 1'b0;
  assign tx_words    = word_cnt;
  assign mask_eff    = last_mask;
`endif

  assign last_word = (tx_idx == tx_words - 1'b1);

  // Padded frames must not leak stale bytes past the real end of the packet.
  always_comb begin
    tx_word = mem[tx_idx[ADDR_WIDTH-1:0]];
    if (pad_active) begin
      if (tx_idx >= word_cnt) begin
        tx_word = '0;
      end else if (tx_idx == word_cnt - 1'b1) begin
        for (int b = 0; b < 8; b++)
          if (!last_mask[b]) tx_word[8*b +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_engine_packet_available) state_d = RD_REQ;
      RD_REQ:  state_d = i_engine_fifo_empty ? RELEASE : RD_CAPT;
      RD_CAPT: state_d = RD_REQ;
      RELEASE: state_d = (overflow || word_cnt == '0) ? IDLE : TX_REQ;
      TX_REQ:  if (i_mac_tx_ack) state_d = TX_DATA;
      TX_DATA: if (last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_engine_fifo_rd_en  = 1'b0;
    o_engine_packet_read = 1'b0;
    o_mac_tx_start       = 1'b0;
    o_mac_tx_data_valid  = 8'h00;
    o_mac_tx_data        = '0;
    o_busy               = (state_q != IDLE);
    case (state_q)
      RD_REQ:  o_engine_fifo_rd_en  = ~i_engine_fifo_empty;
      RELEASE: o_engine_packet_read = 1'b1;
      TX_REQ:  o_mac_tx_start       = 1'b1;
      TX_DATA: begin
        o_mac_tx_data_valid = last_word ? mask_eff : 8'hFF;
        o_mac_tx_data       = tx_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (state_q == RD_CAPT && word_cnt < DEPTH)
      mem[word_cnt[ADDR_WIDTH-1:0]] <= i_engine_fifo_rd_data;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      word_cnt     <= '0;
      tx_idx       <= '0;
      overflow     <= 1'b0;
      bytes_last   <= 4'd0;
      o_tx_packets <= 32'd0;
      o_tx_drops   <= 32'd0;
    end else begin
      if (state_q != TX_DATA) tx_idx <= '0;
      case (state_q)
        IDLE: if (i_engine_packet_available) begin
          bytes_last <= i_engine_bytes_last_word;
          word_cnt   <= '0;
          overflow   <= 1'b0;
        end
        RD_CAPT: begin
          if (word_cnt < DEPTH) word_cnt <= word_cnt + 1'b1;
          else                  overflow <= 1'b1;
        end
        RELEASE: if (overflow || word_cnt == '0) o_tx_drops <= o_tx_drops + 32'd1;
        TX_DATA: begin
          tx_idx <= tx_idx + 1'b1;
          if (last_word) o_tx_packets <= o_tx_packets + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nts_tx_mac_feeder.sv
// Randomized scoreboard bench for nts_tx_mac_feeder: an engine FIFO model and MAC ack responder drive the DUT,
// a frame-level reference model predicts beats and counters.
module tb_nts_tx_mac_feeder;

  localparam int DEPTH = 256;

  logic        i_clk = 1'b0;
  logic        i_areset_n;
  logic        i_engine_packet_available;
  logic        o_engine_packet_read;
  logic        i_engine_fifo_empty;
  logic        o_engine_fifo_rd_en;
  logic [63:0] i_engine_fifo_rd_data;
  logic [3:0]  i_engine_bytes_last_word;
  logic        o_mac_tx_start;
  logic        i_mac_tx_ack;
  logic [7:0]  o_mac_tx_data_valid;
  logic [63:0] o_mac_tx_data;
  logic        o_busy;
  logic [31:0] o_tx_packets;
  logic [31:0] o_tx_drops;

  nts_tx_mac_feeder dut (
    .i_clk                    (i_clk),
    .i_areset_n               (i_areset_n),
    .i_engine_packet_available(i_engine_packet_available),
    .o_engine_packet_read     (o_engine_packet_read),
    .i_engine_fifo_empty      (i_engine_fifo_empty),
    .o_engine_fifo_rd_en      (o_engine_fifo_rd_en),
    .i_engine_fifo_rd_data    (i_engine_fifo_rd_data),
    .i_engine_bytes_last_word (i_engine_bytes_last_word),
    .o_mac_tx_start           (o_mac_tx_start),
    .i_mac_tx_ack             (i_mac_tx_ack),
    .o_mac_tx_data_valid      (o_mac_tx_data_valid),
    .o_mac_tx_data            (o_mac_tx_data),
    .o_busy                   (o_busy),
    .o_tx_packets             (o_tx_packets),
    .o_tx_drops               (o_tx_drops)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  v;
    bit          last;
  } beat_t;

  beat_t       sb_q[$];
  logic [63:0] eng_q[$];
  int errors = 0, checks = 0;
  bit rd_pend = 0, in_frame = 0;
  int rd_cnt = 0, pr_cnt = 0, start_cyc = 0, ack_cnt = 0, ack_delay = 0;
  int m_pkts = 0, m_drops = 0, exp_start = 0, exp_rd = 0, pr0 = 0;

  function automatic logic [7:0] top_mask(int n);
    logic [7:0] m;
    m = 8'h00;
    for (int b = 0; b < n; b++) m[7-b] = 1'b1;
    return m;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor, engine FIFO model and MAC ack responder; outputs are sampled before inputs change.
  always @(negedge i_clk) begin
    beat_t e;
    if (i_areset_n) begin
      if (o_mac_tx_data_valid != 8'h00) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data_valid %0h expected no beat", o_mac_tx_data_valid);
        end else begin
          e = sb_q.pop_front();
          check("beat_data", o_mac_tx_data, e.d);
          check("beat_valid", {56'd0, o_mac_tx_data_valid}, {56'd0, e.v});
          in_frame = !e.last;
        end
      end else begin
        if (in_frame) begin
          checks++; errors++;
          $display("FAIL frame_gap: got data_valid 0 expected contiguous beat");
          in_frame = 0;
        end
        check("idle_data_zero", o_mac_tx_data, 64'd0);
      end

      if (o_engine_packet_read) begin
        pr_cnt++;
        i_engine_packet_available = 1'b0;
      end

      if (rd_pend) begin
        if (eng_q.size() > 0) i_engine_fifo_rd_data = eng_q.pop_front();
        i_engine_fifo_empty = (eng_q.size() == 0);
        rd_pend = 0;
      end else begin
        i_engine_fifo_rd_data = {$urandom, $urandom};
      end
      if (o_engine_fifo_rd_en) begin
        rd_pend = 1;
        rd_cnt++;
      end

      if (o_mac_tx_start) begin
        i_mac_tx_ack = (ack_cnt == ack_delay);
        ack_cnt++;
        start_cyc++;
      end else begin
        ack_cnt = 0;
        i_mac_tx_ack = (o_mac_tx_data_valid != 8'h00) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic load_pkt(int k, logic [3:0] n, int delay);
    logic [63:0] w[$];
    int    ne, total;
    bit    pad;
    beat_t b;
    logic [7:0]  tm;
    logic [63:0] dm;
    for (int i = 0; i < k; i++) w.push_back({$urandom, $urandom});
    for (int i = 0; i < k; i++) eng_q.push_back(w[i]);
    ne = (n == 0 || n > 8) ? 8 : int'(n);
    tm = top_mask(ne);
    if (k == 0 || k > DEPTH) begin
      m_drops++;
      exp_start = 0;
    end else begin
      total = k;
      pad = 0;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
      if ((k - 1) * 8 + ne < 60) begin
        total = 8;
        pad = 1;
      end
`endif
      dm = 64'd0;
      for (int j = 0; j < 8; j++) if (tm[j]) dm[8*j +: 8] = 8'hFF;
      for (int i = 0; i < total; i++) begin
        b.d = (i < k) ? w[i] : 64'd0;
        if (pad && i == k - 1) b.d = b.d & dm;
        b.v = 8'hFF;
        if (i == total - 1) b.v = pad ? 8'hF0 : tm;
        b.last = (i == total - 1);
        sb_q.push_back(b);
      end
      m_pkts++;
      exp_start = delay + 1;
    end
    rd_cnt = 0;
    start_cyc = 0;
    pr0 = pr_cnt;
    exp_rd = k;
    ack_delay = delay;
    i_engine_bytes_last_word = n;
    i_engine_fifo_empty = (k == 0);
    i_engine_packet_available = 1'b1;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!(pr_cnt > pr0 && !o_busy) && c < 3000) begin
      @(posedge i_clk); #1;
      c++;
    end
    checks++;
    if (c >= 3000) begin
      errors++;
      $display("FAIL done_timeout: got busy after %0d cycles expected idle", c);
    end
    check("rd_en_count", 64'(rd_cnt), 64'(exp_rd));
    check("packet_read_pulses", 64'(pr_cnt - pr0), 64'd1);
    check("start_cycles", 64'(start_cyc), 64'(exp_start));
    check("beats_left", 64'(sb_q.size()), 64'd0);
    check("tx_packets", {32'd0, o_tx_packets}, 64'(m_pkts));
    check("tx_drops", {32'd0, o_tx_drops}, 64'(m_drops));
    @(posedge i_clk); #1;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    check({tag, "_start"}, {63'd0, o_mac_tx_start}, 64'd0);
    check({tag, "_rd_en"}, {63'd0, o_engine_fifo_rd_en}, 64'd0);
    check({tag, "_pkt_read"}, {63'd0, o_engine_packet_read}, 64'd0);
    check({tag, "_valid"}, {56'd0, o_mac_tx_data_valid}, 64'd0);
    check({tag, "_data"}, o_mac_tx_data, 64'd0);
    check({tag, "_packets"}, {32'd0, o_tx_packets}, 64'd0);
    check({tag, "_drops"}, {32'd0, o_tx_drops}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    i_areset_n = 1'b0;
    i_engine_packet_available = 1'b0;
    i_engine_fifo_empty = 1'b1;
    i_engine_fifo_rd_data = 64'd0;
    i_engine_bytes_last_word = 4'd0;
    i_mac_tx_ack = 1'b0;
    #3;
    check_outputs_zero("reset");
    #20 i_areset_n = 1'b1;
    @(posedge i_clk); #1;

    load_pkt(10, 4'd6, 3);      wait_done();
    load_pkt(0, 4'd4, 0);       wait_done();
    load_pkt(DEPTH + 1, 4'd8, 1); wait_done();
    load_pkt(3, 4'd2, 0);       wait_done();
    load_pkt(DEPTH, 4'd0, 2);   wait_done();
    load_pkt(4, 4'd9, 1);       wait_done();
    load_pkt(7, 4'd8, 0);       wait_done();
    load_pkt(8, 4'd4, 0);       wait_done();
    load_pkt(1, 4'd1, 4);       wait_done();
    for (int i = 0; i < 12; i++) begin
      load_pkt(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20)),
               4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      wait_done();
    end

    // Reset in the middle of streaming abandons the frame.
    load_pkt(12, 4'd5, 1);
    c = 0;
    while (o_mac_tx_data_valid == 8'h00 && c < 500) begin
      @(posedge i_clk); #1;
      c++;
    end
    checks++;
    if (c >= 500) begin
      errors++;
      $display("FAIL stream_timeout: got no beat expected streaming");
    end
    repeat (3) @(posedge i_clk);
    #2 i_areset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    sb_q.delete();
    eng_q.delete();
    in_frame = 0;
    rd_pend = 0;
    ack_cnt = 0;
    m_pkts = 0;
    m_drops = 0;
    i_engine_packet_available = 1'b0;
    i_engine_fifo_empty = 1'b1;
    i_mac_tx_ack = 1'b0;
    @(posedge i_clk); #3 i_areset_n = 1'b1;
    @(posedge i_clk); #1;
    load_pkt(5, 4'd3, 2);       wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
